lfsr_checker: RTL and testbench
===============================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 LOCK_CNT, 16: consecutive matching bits in SYNC required to declare lock (range 1..255).
REQ-002 LOSS_CNT, 4: consecutive mismatching bits in LOCKED that cause loss of lock (range 1..15).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  din valid this cycle; when low, no internal state changes.
REQ-006 din  input  1  received serial bit of the 8-bit XNOR PRBS (taps 7 and 3, new bit = NOT(s[7] XOR s[3]), shifted in at bit 0).
REQ-007 clear_cnt  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  checker is synchronised to the sequence.
REQ-009 err_pulse  output  1  one-cycle pulse per mismatched bit while LOCKED.
REQ-010 err_count  output  16  saturating count of mismatches in LOCKED.
REQ-011 state  output  2  FSM state: 0 HUNT, 1 SYNC, 2 LOCKED.

Function
REQ-012 Checker SHALL hold an 8-bit history register r; predicted bit p = NOT(r[7] XOR r[3]).
REQ-013 Update SHALL occur only on cycles with enable=1; all outputs are registered, reflecting a bit one cycle after it is presented.
REQ-014 HUNT: each enabled bit shifts din into r[0]; after 8 enabled bits -> SYNC with match counter 0.
REQ-015 SYNC: din shifts into r; din==p increments match counter, din!=p clears it; counter reaching LOCK_CNT -> LOCKED, locked=1 the same edge.
REQ-016 SYNC: while r==8'hFF before the shift (XNOR lockup), a "match" SHALL NOT count and SHALL clear the match counter (stuck-at-1 input never locks).
REQ-017 LOCKED: din!=p asserts err_pulse for one cycle, increments err_count and the consecutive-error counter; din==p clears the consecutive-error counter.
REQ-018 LOCKED: consecutive-error counter reaching LOSS_CNT -> HUNT, locked=0 the same edge, fill counter 0; the LOSS_CNT-th error is still counted and pulsed.
REQ-019 err_count SHALL saturate at 16'hFFFF and never wrap.
REQ-020 clear_cnt with a simultaneous counted error SHALL yield err_count=1; clear_cnt alone yields 0.
REQ-021 err_pulse SHALL be 0 in any cycle with enable=0 and in HUNT/SYNC.
REQ-022 State encoding 3 is illegal and SHALL transition to HUNT on the next clock.

Reset
REQ-023 reset=1 SHALL, at the next edge, set state=HUNT, r=0, all internal counters=0, locked=0, err_pulse=0, err_count=0, overriding enable and clear_cnt.
REQ-024 Reset mid-operation SHALL discard lock; re-lock requires a full 8 + LOCK_CNT enabled bits.

Configuration
REQ-025 Macro LFSR_CHK_FLYWHEEL_EN defined: in LOCKED, r SHALL shift in p (not din), so one channel bit error gives exactly one err_pulse.
REQ-026 Macro undefined: in LOCKED, r SHALL shift in din, so one channel bit error produces up to 3 err_pulses (direct, tap-3 and tap-7 echoes); all other behaviour identical.

Verification
REQ-027 Generator stream from seed 0, enable=1 continuously -> locked=1 after exactly 24 enabled bits (state 0->1 at bit 8, 1->2 at bit 24); err_count=0 after 2000 bits.
REQ-028 Locked, flip bit 100 only -> with FLYWHEEL_EN: one err_pulse, err_count=1, locked stays 1; without: err_count=3, locked stays 1.
REQ-029 Locked, flip 4 consecutive bits -> err_count=4, locked=0, state=HUNT after 4th bit; clean stream then relocks after 24 more bits.
REQ-030 din held 1 for 200 enabled bits after reset -> locked never asserts, state stays SYNC, err_count=0.
REQ-031 Locked, enable toggling 1/0 with random gaps -> no state change on enable=0 cycles, locked held, err_count=0; clear_cnt coincident with an error -> err_count=1.
REQ-032 Locked with err_count=5, assert reset one cycle -> next cycle all outputs 0, state=HUNT; relock after 24 bits.

Source files
------------

// File: rtl/lfsr_checker.sv
// PRBS-8 XNOR (taps 7,3) sync/lock checker with error pulse and saturating error count.
// Latency: outputs registered, valid one cycle after the bit is presented; enable=0 freezes all state.
// Optional LFSR_CHK_FLYWHEEL_EN: when locked, history is fed by the prediction so one channel error gives one pulse.
module lfsr_checker #(
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        din,
    input  logic        clear_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [15:0] err_count,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SYNC    = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

    state_t      state_q, state_d;
    logic [7:0]  r_q, r_d;
    logic [2:0]  fill_q, fill_d;
    logic [7:0]  match_q, match_d;
    logic [3:0]  run_q, run_d;
    logic [15:0] err_count_q, err_count_d;
    logic        err_pulse_q, err_pulse_d;
    logic        locked_q, locked_d;

    logic        pred;
    logic        mismatch;
    logic        err_hit;

    assign pred     = ~(r_q[7] ^ r_q[3]);
    assign mismatch = din ^ pred;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        match_d     = match_q;
        run_d       = run_q;
        err_count_d = err_count_q;
        err_pulse_d = 1'b0;
        locked_d    = locked_q;
        err_hit     = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (enable) begin
                    r_d = {r_q[6:0], din};
                    if (fill_q == 3'd7) begin
                        state_d = ST_SYNC;
                        fill_d  = 3'd0;
                        match_d = 8'd0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
            end

            ST_SYNC: begin
                if (enable) begin
                    r_d = {r_q[6:0], din};
                    // An all-ones history is the XNOR lockup state: stuck-at-1 input must never lock.
                    if ((r_q != 8'hFF) && !mismatch) begin
                        if (match_q == LOCK_LAST) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            match_d  = 8'd0;
                            run_d    = 4'd0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        match_d = 8'd0;
                    end
                end
            end

            ST_LOCKED: begin
                if (enable) begin
`ifdef LFSR_CHK_FLYWHEEL_EN
                    r_d = {r_q[6:0], pred};
`else
                    r_d = {r_q[6:0], din};
`endif
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_hit     = 1'b1;
                        if (run_q == LOSS_LAST) begin
                            state_d  = ST_HUNT;
                            locked_d = 1'b0;
                            fill_d   = 3'd0;
                            match_d  = 8'd0;
                            run_d    = 4'd0;
                        end else begin
                            run_d = run_q + 4'd1;
                        end
                    end else begin
                        run_d = 4'd0;
                    end
                end
            end

            default: begin
                state_d  = ST_HUNT;
                locked_d = 1'b0;
                fill_d   = 3'd0;
                match_d  = 8'd0;
                run_d    = 4'd0;
            end
        endcase

        // A clear coincident with a counted error keeps that error.
        if (clear_cnt) begin
            err_count_d = {15'd0, err_hit};
        end else if (err_hit && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            r_q         <= 8'd0;
            fill_q      <= 3'd0;
            match_q     <= 8'd0;
            run_q       <= 4'd0;
            err_count_q <= 16'd0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            run_q       <= run_d;
            err_count_q <= err_count_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: a reference model queues expected outputs per driven bit.
module tb_lfsr_checker;
    localparam int LOCK_CNT = 16;
    localparam int LOSS_CNT = 4;
`ifdef LFSR_CHK_FLYWHEEL_EN
    localparam int FLY = 1;
`else
    localparam int FLY = 0;
`endif
    localparam int EXP_SINGLE = (FLY != 0) ? 1 : 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        din = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [1:0]  state;
    logic [19:0] got;
    logic [19:0] exp;
    logic [19:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  g_s;
    int m_state, m_fill, m_match, m_run, m_cnt;
    logic [7:0] m_r;
    logic m_pulse, m_locked;

    lfsr_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT)) dut (
        .clk(clk), .reset(reset), .enable(enable), .din(din), .clear_cnt(clear_cnt),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .state(state)
    );

    always #5 clk = ~clk;
    assign got = {state, locked, err_pulse, err_count};

    task automatic gen(output logic b);
        b   = ~(g_s[7] ^ g_s[3]);
        g_s = {g_s[6:0], b};
    endtask

    // Advance the model, queue its expectation, then present the inputs for one clock.
    task automatic step(input logic en, input logic d, input logic clr, input logic rst);
        logic p, hit;
        hit = 1'b0;
        if (rst) begin
            m_state = 0; m_r = 8'd0; m_fill = 0; m_match = 0; m_run = 0;
            m_cnt = 0; m_pulse = 1'b0; m_locked = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (en) begin
                p = ~(m_r[7] ^ m_r[3]);
                case (m_state)
                    0: begin
                        m_r = {m_r[6:0], d};
                        m_fill++;
                        if (m_fill == 8) begin m_state = 1; m_fill = 0; m_match = 0; end
                    end
                    1: begin
                        if (m_r != 8'hFF && d == p) m_match++; else m_match = 0;
                        m_r = {m_r[6:0], d};
                        if (m_match == LOCK_CNT) begin m_state = 2; m_locked = 1'b1; m_run = 0; m_match = 0; end
                    end
                    default: begin
                        m_r = {m_r[6:0], (FLY != 0) ? p : d};
                        if (d != p) begin
                            hit = 1'b1; m_pulse = 1'b1; m_run++;
                            if (m_run == LOSS_CNT) begin m_state = 0; m_locked = 1'b0; m_fill = 0; m_run = 0; end
                        end else begin
                            m_run = 0;
                        end
                    end
                endcase
            end
            if (clr) m_cnt = hit ? 1 : 0;
            else if (hit && m_cnt < 65535) m_cnt++;
        end
        exp_q.push_back({m_state[1:0], m_locked, m_pulse, m_cnt[15:0]});
        reset = rst; enable = en; din = d; clear_cnt = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b1);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp || got !== 20'd0) begin
                n_err++; $display("FAIL reset_state got=%h exp=%h", got, exp);
            end
        end
    endtask

    task automatic test_lock_acquire();
        logic b;
        g_s = 8'd0;
        for (int i = 1; i <= 2000; i++) begin
            gen(b);
            step(1'b1, b, 1'b0, 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL acquire_trk bit=%0d got=%h exp=%h", i, got, exp); end
            if (i == 7 || i == 8 || i == 23 || i == 24) begin
                n_cmp++;
                if (state !== ((i == 7) ? 2'd0 : (i == 24) ? 2'd2 : 2'd1) || locked !== (i == 24)) begin
                    n_err++; $display("FAIL acquire_time bit=%0d state=%0d locked=%0d", i, state, locked);
                end
            end
        end
        n_cmp++;
        if (err_count !== 16'd0 || locked !== 1'b1) begin
            n_err++; $display("FAIL acquire_2000 err_count=%0d locked=%0d need 0/1", err_count, locked);
        end
    endtask

    task automatic test_single_flip();
        logic b;
        int pulses;
        pulses = 0;
        gen(b);
        step(1'b1, b, 1'b1, 1'b0);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL flip_clear got=%h exp=%h", got, exp); end
        for (int i = 1; i <= 120; i++) begin
            gen(b);
            step(1'b1, (i == 100) ? ~b : b, 1'b0, 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL flip_trk bit=%0d got=%h exp=%h", i, got, exp); end
            if (err_pulse === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != EXP_SINGLE || err_count !== 16'(EXP_SINGLE) || locked !== 1'b1) begin
            n_err++;
            $display("FAIL flip_total pulses=%0d err_count=%0d locked=%0d need %0d/%0d/1",
                     pulses, err_count, locked, EXP_SINGLE, EXP_SINGLE);
        end
    endtask

    task automatic test_loss_relock();
        logic b;
        for (int i = 1; i <= 14; i++) begin
            gen(b);
            step(1'b1, (i > 10) ? ~b : b, (i == 1), 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL loss_trk bit=%0d got=%h exp=%h", i, got, exp); end
        end
        n_cmp++;
        if (err_count !== 16'd4 || locked !== 1'b0 || state !== 2'd0) begin
            n_err++; $display("FAIL loss_state err_count=%0d locked=%0d state=%0d need 4/0/0", err_count, locked, state);
        end
        for (int i = 1; i <= 24; i++) begin
            gen(b);
            step(1'b1, b, 1'b0, 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL relock_trk bit=%0d got=%h exp=%h", i, got, exp); end
            if (i == 23 || i == 24) begin
                n_cmp++;
                if (locked !== (i == 24)) begin n_err++; $display("FAIL relock_time bit=%0d locked=%0d", i, locked); end
            end
        end
    endtask

    task automatic test_enable_gaps();
        logic b, en;
        logic [2:0] prev;
        gen(b);
        step(1'b1, b, 1'b1, 1'b0);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL gaps_clear got=%h exp=%h", got, exp); end
        for (int i = 0; i < 300; i++) begin
            en = 1'($urandom_range(0, 1));
            if (en) gen(b); else b = 1'($urandom_range(0, 1));
            prev = {state, locked};
            step(en, b, 1'b0, 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp || (!en && ({state, locked} !== prev || err_pulse !== 1'b0))) begin
                n_err++; $display("FAIL gaps_trk i=%0d en=%0d got=%h exp=%h", i, en, got, exp);
            end
        end
        n_cmp++;
        if (locked !== 1'b1 || err_count !== 16'd0) begin
            n_err++; $display("FAIL gaps_hold locked=%0d err_count=%0d need 1/0", locked, err_count);
        end
        for (int i = 1; i <= 32; i++) begin
            gen(b);
            step(1'b1, (i == 1 || i == 12) ? ~b : b, (i == 12 || i == 32), 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL clrerr_trk bit=%0d got=%h exp=%h", i, got, exp); end
            if (i == 12 || i == 32) begin
                n_cmp++;
                if (err_count !== ((i == 12) ? 16'd1 : 16'd0)) begin
                    n_err++; $display("FAIL clear_cnt bit=%0d err_count=%0d", i, err_count);
                end
            end
        end
    endtask

    task automatic test_stuck_one();
        int seen_lock;
        seen_lock = 0;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL stuck_reset got=%h exp=%h", got, exp); end
        for (int i = 1; i <= 200; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL stuck_trk bit=%0d got=%h exp=%h", i, got, exp); end
            if (locked === 1'b1) seen_lock++;
        end
        n_cmp++;
        if (seen_lock != 0 || state !== 2'd1 || err_count !== 16'd0) begin
            n_err++; $display("FAIL stuck_one locks=%0d state=%0d err_count=%0d need 0/1/0", seen_lock, state, err_count);
        end
    endtask

    task automatic test_reset_mid();
        logic b;
        logic flip;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp) begin n_err++; $display("FAIL mid_reset0 got=%h exp=%h", got, exp); end
        // Flywheel: five isolated flips. Direct feed: one isolated flip (3 errors) plus a pair 4 apart (2 errors).
        for (int i = 1; i <= 160; i++) begin
            gen(b);
            if (FLY != 0) flip = (i > 30) && (i % 25 == 0);
            else flip = (i == 50) || (i == 100) || (i == 104);
            step(1'b1, flip ? ~b : b, 1'b0, 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL mid_trk bit=%0d got=%h exp=%h", i, got, exp); end
        end
        n_cmp++;
        if (err_count !== 16'd5 || locked !== 1'b1) begin
            n_err++; $display("FAIL mid_count err_count=%0d locked=%0d need 5/1", err_count, locked);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        exp = exp_q.pop_front(); n_cmp++;
        if (got !== exp || got !== 20'd0) begin n_err++; $display("FAIL mid_reset got=%h exp=%h", got, exp); end
        for (int i = 1; i <= 24; i++) begin
            gen(b);
            step(1'b1, b, 1'b0, 1'b0);
            exp = exp_q.pop_front(); n_cmp++;
            if (got !== exp) begin n_err++; $display("FAIL mid_relock bit=%0d got=%h exp=%h", i, got, exp); end
            if (i == 23 || i == 24) begin
                n_cmp++;
                if (locked !== (i == 24)) begin n_err++; $display("FAIL mid_relock_time bit=%0d locked=%0d", i, locked); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_single_flip();
        test_loss_relock();
        test_enable_gaps();
        test_stuck_one();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
